conv_col_sched: RTL and testbench
=================================

# conv_col_sched

Sequencer for the conv1 column MAC unit (`conv_col`, 11 pixels × 11 signed weights per cycle, 3-stage pipeline, 23-bit accumulator). It sweeps one output row of a stride-4, 11×11 convolution. For each output position it issues 11 consecutive column reads to the image line buffer and the filter-column ROM, and asserts `acc_clear` at the pipeline-aligned cycle. It captures each finished accumulator value into a 2-entry result queue with a valid/ready handshake toward the output writer.

## Interface

Parameters:

- KSIZE, 11, kernel width in columns (columns per window)
- STRIDE, 4, column step between adjacent windows
- OUT_W, 55, windows per row
- IMG_W, 227, line-buffer width; must satisfy (OUT_W-1)*STRIDE+KSIZE ≤ IMG_W
- MEM_LAT, 1, read latency (cycles) of line buffer and filter ROM, both equal
- ACC_W, 23, accumulator/result width

Ports:

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse; begins a row sweep when idle; ignored while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last result of the row is written into the queue
- col_req  out  1  column read strobe to line buffer and filter ROM
- col_addr  out  clog2(IMG_W)  line-buffer column index
- filt_idx  out  clog2(KSIZE)  filter column index 0..KSIZE-1
- acc_clear  out  1  to conv_col; restarts accumulation
- acc_in  in  ACC_W  conv_col accumulator output
- res_data  out  ACC_W  queue head value
- res_x  out  clog2(OUT_W)  output column of queue head
- res_valid  out  1  queue non-empty
- res_ready  in  1  consumer accepts head when res_valid high

## Operation

- FSM states:
  - IDLE: start → ISSUE with x=0, k=0.
  - ISSUE: each cycle drive col_req=1, col_addr=x*STRIDE+k, filt_idx=k; k increments. When k=KSIZE-1, set k=0 and x+1.
    - Before issuing k=0 of window x, require credits > 0; otherwise → STALL.
    - After issuing the last column of window OUT_W-1 → DRAIN.
  - STALL: col_req=0; → ISSUE in the first cycle credits > 0. Issue restarts at k=0.
  - DRAIN: col_req=0; when no window is in flight → IDLE, pulse done.
- Credits: 2 minus (queue occupancy + windows issued but not yet captured). A window takes its credit at its k=0 issue. Its credit returns when the consumer pops its result (res_valid&&res_ready).
- Alignment uses a delay line of per-column tags {first, last, x} with depth MEM_LAT+3. No datapath stall exists, so the tags must track issue exactly.
  - acc_clear=1 exactly MEM_LAT+2 cycles after a k=0 issue, else 0.
  - Capture: MEM_LAT+3 cycles after a k=KSIZE-1 issue, acc_in holds the complete sum. Write {acc_in, x} into the queue at the end of that cycle.
- During STALL, conv_col keeps accumulating stale products. This is harmless: the next acc_clear discards them.
- Queue: 2-entry FIFO, first-in first-out. Push and pop in the same cycle are legal, including when full, because credits prevent a third entry. Push to a full queue cannot occur; the bench asserts this.
- Widths: col_addr computed at full clog2(IMG_W); no wrap is possible under the parameter constraint. res_data is acc_in unmodified; no saturation.
- rst at any time: FSM→IDLE, x,k=0, tag line cleared, queue emptied, credits=2.

## Timing

- Reset values: busy=0, done=0, col_req=0, col_addr=0, filt_idx=0, acc_clear=0, res_valid=0, res_data=0, res_x=0.
- start sampled in cycle t → busy=1 and first col_req in cycle t+1.
- Unstalled throughput: one window per KSIZE cycles; windows are issued back-to-back with no bubble.
- Window latency: k=0 issue at cycle s → res_valid at s+KSIZE-1+MEM_LAT+4 (MEM_LAT=1: s+15).
- done pulses in the cycle after the final queue write; busy falls in the same cycle.
- start coincident with rst: rst wins.

## Structure

- Shared package alexnet_pkg: KSIZE, STRIDE, OUT_W, IMG_W, ACC_W constants; FSM state enum; tag struct {first, last, x}.
- One sub-module: conv_res_fifo, a 2-entry {ACC_W + clog2(OUT_W)}-bit synchronous FIFO with push/pop, full/empty, and synchronous reset.

## Test plan

- Reset mid-row: rst asserted at window 7 → all outputs at reset values next cycle. A new start then yields res_x=0 first.
- Single row, res_ready tied 1, MEM_LAT=1, behavioural conv_col with all pixels=1 and all weights=1 → 55 results, each res_data=121 and res_x=0..54 in order. Cadence is 11 cycles. The first res_valid appears 15 cycles after the first col_req. done follows the last write.
- Signed check with weights=-1 (8'hFF) and pixels=255 → res_data=-30855 (23'h7F8779) for every x.
- Backpressure: res_ready held 0 → exactly 2 results are queued, col_req drops (STALL), and no overflow occurs. res_ready then pulsed once → one window is issued, then stall again. Ordering is preserved.
- Address trace: log col_addr/filt_idx → window x covers 4x..4x+10. Window 54 ends at column 226; filt_idx cycles 0..10.
- Ignored start: start pulsed mid-row → no restart, x sequence unchanged. acc_clear count equals 55 per row.

Source files
------------

// File: rtl/alexnet_pkg.sv
// ============================================================================
// alexnet_pkg : shared conv1 constants, scheduler state and pipeline tag types
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alexnet_pkg;

  localparam int KSIZE  = 11;
  localparam int STRIDE = 4;
  localparam int OUT_W  = 55;
  localparam int IMG_W  = 227;
  localparam int ACC_W  = 23;

  localparam int XW = $clog2(OUT_W);
  localparam int AW = $clog2(IMG_W);
  localparam int KW = $clog2(KSIZE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_STALL = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic          first;
    logic          last;
    logic [XW-1:0] x;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/conv_res_fifo.sv
// ============================================================================
// conv_res_fifo : 2-entry synchronous result FIFO, push/pop legal together
// Revision      : 1.0
// ============================================================================
`default_nettype none

module conv_res_fifo #(
  parameter int W = 29
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wp_q, wp_d, rp_q, rp_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  always_comb begin
    full    = (cnt_q == 2'd2);
    empty   = (cnt_q == 2'd0);
    rdata   = mem_q[rp_q];
    do_pop  = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    if (do_push) begin
      mem_d[wp_q] = wdata;
      wp_d        = ~wp_q;
    end
    if (do_pop) rp_d = ~rp_q;
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_col_sched.sv
// ============================================================================
// conv_col_sched : conv1 row sweep sequencer with credit-limited result queue
// Revision       : 1.0
// ============================================================================
`default_nettype none

module conv_col_sched import alexnet_pkg::*; #(
  parameter int KSIZE   = alexnet_pkg::KSIZE,
  parameter int STRIDE  = alexnet_pkg::STRIDE,
  parameter int OUT_W   = alexnet_pkg::OUT_W,
  parameter int IMG_W   = alexnet_pkg::IMG_W,
  parameter int MEM_LAT = 1,
  parameter int ACC_W   = alexnet_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     col_req,
  output logic [$clog2(IMG_W)-1:0] col_addr,
  output logic [$clog2(KSIZE)-1:0] filt_idx,
  output logic                     acc_clear,
  input  logic [ACC_W-1:0]         acc_in,
  output logic [ACC_W-1:0]         res_data,
  output logic [$clog2(OUT_W)-1:0] res_x,
  output logic                     res_valid,
  input  logic                     res_ready
);

  localparam int AWL   = $clog2(IMG_W);
  localparam int KWL   = $clog2(KSIZE);
  localparam int XWL   = $clog2(OUT_W);
  localparam int DEPTH = MEM_LAT + 3;

  state_e           state_q, state_d;
  logic [XWL-1:0]   x_q, x_d;
  logic [KWL-1:0]   k_q, k_d;
  logic [1:0]       infl_q, infl_d;
  logic             done_q, done_d;
  tag_t             tag_q [DEPTH];
  tag_t             tag_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;

  logic             last_col, win_start, credit_ok, push, pop, q_full, q_empty;
  logic [2:0]       used;
  logic [ACC_W+XWL-1:0] q_rdata;

  always_comb begin
    // Occupancy plus windows still in the pipe must stay below two
    used      = (q_full ? 3'd2 : (q_empty ? 3'd0 : 3'd1)) + {1'b0, infl_q};
    credit_ok = (used < 3'd2);
    last_col  = (k_q == KWL'(KSIZE - 1));
    col_req   = (state_q == S_ISSUE) && ((k_q != '0) || credit_ok);
    win_start = col_req && (k_q == '0);
    col_addr  = AWL'(x_q) * AWL'(STRIDE) + AWL'(k_q);
    filt_idx  = k_q;
    acc_clear = vld_q[DEPTH-2] && tag_q[DEPTH-2].first;
    push      = vld_q[DEPTH-1] && tag_q[DEPTH-1].last;
    pop       = res_valid && res_ready;
    busy      = (state_q != S_IDLE);
    done      = done_q;
    res_valid = !q_empty;
    res_data  = q_rdata[ACC_W+XWL-1:XWL];
    res_x     = q_rdata[XWL-1:0];
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    k_d     = k_q;
    done_d  = 1'b0;
    infl_d  = infl_q + {1'b0, win_start} - {1'b0, push};
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: begin
        if (col_req) begin
          if (last_col) begin
            k_d = '0;
            if (x_q == XWL'(OUT_W - 1)) begin
              x_d     = '0;
              state_d = S_DRAIN;
            end else begin
              x_d = x_q + 1'b1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end else begin
          state_d = S_STALL;
        end
      end
      S_STALL: if (credit_ok) state_d = S_ISSUE;
      S_DRAIN: begin
        if (push && (infl_q == 2'd1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tag line mirrors the memory + conv_col pipeline one entry per issued column
  always_comb begin
    tag_d[0].first = (k_q == '0);
    tag_d[0].last  = last_col;
    tag_d[0].x     = XW'(x_q);
    vld_d          = {vld_q[DEPTH-2:0], col_req};
    for (int i = 1; i < DEPTH; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      k_q     <= '0;
      infl_q  <= 2'd0;
      done_q  <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      k_q     <= k_d;
      infl_q  <= infl_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      tag_q   <= tag_d;
    end
  end

  conv_res_fifo #(
    .W (ACC_W + XWL)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({acc_in, XWL'(tag_q[DEPTH-1].x)}),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_conv_col_sched.sv
// ============================================================================
// tb_conv_col_sched : directed bench with a behavioural conv_col (MEM_LAT=1)
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_conv_col_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        res_ready = 1'b1;
  logic        busy, done, col_req, acc_clear, res_valid;
  logic [7:0]  col_addr;
  logic [3:0]  filt_idx;
  logic [5:0]  res_x;
  logic [22:0] res_data;
  logic signed [22:0] acc_in;

  int pix = 1;
  int wt  = 1;

  always #5 clk = ~clk;

  conv_col_sched #(.MEM_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .col_req   (col_req),
    .col_addr  (col_addr),
    .filt_idx  (filt_idx),
    .acc_clear (acc_clear),
    .acc_in    (acc_in),
    .res_data  (res_data),
    .res_x     (res_x),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  // conv_col stand-in: memory stage, product stage, column-sum stage, accumulator
  logic signed [22:0] s1 = '0, s2 = '0, s3 = '0, acc = '0;
  always @(posedge clk) begin
    s1  <= col_req ? 23'(11 * pix * wt) : 23'sd999;
    s2  <= s1;
    s3  <= s2;
    acc <= acc_clear ? s3 : acc + s3;
  end
  assign acc_in = acc;

  int n_chk = 0, n_err = 0;
  int cyc = 0, exp_x = 0, exp_k = 0, exp_rx = 0;
  int n_pop = 0, n_req = 0, n_clr = 0, cad_bad = 0;
  int first_req = -1, first_val = -1, last_pop = -1, done_cyc = -1, last_addr = -1;
  logic [22:0] exp_val = 23'd121;
  logic        ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr_row();
    exp_x = 0; exp_k = 0; exp_rx = 0; n_pop = 0; n_req = 0; n_clr = 0; cad_bad = 0;
    first_req = -1; first_val = -1; last_pop = -1; done_cyc = -1; last_addr = -1;
  endtask

  task automatic monitor();
    cyc++;
    if (rst) begin
      clr_row();
    end else begin
      if (col_req) begin
        check("col_addr", 32'(col_addr), 32'(exp_x * 4 + exp_k));
        check("filt_idx", 32'(filt_idx), 32'(exp_k));
        if (first_req < 0) first_req = cyc;
        last_addr = int'(col_addr);
        n_req++;
        if (exp_k == 10) begin exp_k = 0; exp_x++; end
        else exp_k++;
      end
      if (acc_clear) n_clr++;
      if (res_valid && first_val < 0) first_val = cyc;
      if (res_valid && res_ready) begin
        check("res_x", 32'(res_x), 32'(exp_rx));
        check("res_data", 32'(res_data), 32'(exp_val));
        if (n_pop > 0 && (cyc - last_pop) != 11) cad_bad++;
        last_pop = cyc;
        n_pop++;
        exp_rx++;
      end
      if (done) begin
        done_cyc = cyc;
        check("busy_at_done", 32'(busy), 32'd0);
      end
      if (dut.push && dut.q_full && !dut.pop) ovf = 1'b1;
    end
  endtask

  task automatic step();
    #1;
    monitor();
    @(negedge clk);
  endtask

  task automatic do_start();
    clr_row();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_row(input int bound, input int poke);
    for (int i = 0; i < bound && done_cyc < 0; i++) begin
      start = (i == poke);
      step();
    end
    start = 1'b0;
    if (done_cyc < 0) check("row_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_col_req"},   32'(col_req),   32'd0);
    check({tag, "_col_addr"},  32'(col_addr),  32'd0);
    check({tag, "_filt_idx"},  32'(filt_idx),  32'd0);
    check({tag, "_acc_clear"}, 32'(acc_clear), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"},  32'(res_data),  32'd0);
    check({tag, "_res_x"},     32'(res_x),     32'd0);
  endtask

  initial begin
    @(negedge clk);
    repeat (3) step();
    chk_reset("rst");
    rst = 1'b0;
    step();

    // Full row, all ones, with a start pulse mid-row that must be ignored
    exp_val = 23'd121;
    do_start();
    run_row(1500, 100);
    check("ones_pops",   32'(n_pop), 32'd55);
    check("ones_clears", 32'(n_clr), 32'd55);
    check("ones_reqs",   32'(n_req), 32'd605);
    check("ones_lat",    32'(first_val - first_req), 32'd15);
    check("ones_cad",    32'(cad_bad), 32'd0);
    check("ones_done",   32'(done_cyc), 32'(last_pop));
    check("ones_lastad", 32'(last_addr), 32'd226);
    repeat (3) step();

    // Signed products: 11*11*255*(-1) = -30855
    pix = 255; wt = -1; exp_val = 23'h7F8779;
    do_start();
    run_row(1500, -1);
    check("neg_pops", 32'(n_pop), 32'd55);
    repeat (3) step();

    // Backpressure: two windows fill the credits, then issue stalls
    pix = 1; wt = 1; exp_val = 23'd121;
    res_ready = 1'b0;
    do_start();
    repeat (60) step();
    check("bp_pops",    32'(n_pop), 32'd0);
    check("bp_reqs",    32'(n_req), 32'd22);
    check("bp_valid",   32'(res_valid), 32'd1);
    check("bp_col_req", 32'(col_req), 32'd0);
    check("bp_busy",    32'(busy), 32'd1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    repeat (40) step();
    check("bp1_pops",    32'(n_pop), 32'd1);
    check("bp1_reqs",    32'(n_req), 32'd33);
    check("bp1_head_x",  32'(res_x), 32'd1);
    check("bp1_col_req", 32'(col_req), 32'd0);
    res_ready = 1'b1;
    run_row(1500, -1);
    check("bp_total", 32'(n_pop), 32'd55);
    repeat (3) step();

    // Reset while window 7 is being issued, then a clean row
    do_start();
    for (int i = 0; i < 300 && exp_x < 7; i++) step();
    check("mid_reached_w7", 32'(exp_x), 32'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("mid");
    do_start();
    run_row(1500, -1);
    check("mid_pops", 32'(n_pop), 32'd55);
    repeat (3) step();

    // start coincident with rst is dropped
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    repeat (2) step();
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_req",  32'(col_req), 32'd0);

    check("no_overflow", 32'(ovf), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
